serial_subtractor: RTL and testbench

Parametrised bit-serial multi-bit subtractor, the sequential successor to the single-bit half subtractor cell. It computes diff = a - b - borrow_in over WIDTH bits, processing BITS_PER_CYCLE bits per clock from LSB to MSB. A registered borrow chain links the chunks. A start/busy/done handshake frames each operation, so the block can sit behind a simple controller in the datapath.

---
 rtl/serial_subtractor.sv | 132 +++++++++++++
 tb/tb_serial_subtractor.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - borrow_in, BITS_PER_CYCLE bits per clock, LSB first.
// A start/busy/done handshake frames each operation; results hold until the next completion.
`timescale 1ns/1ps
module serial_subtractor #(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             zero
);

    localparam int N     = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    generate
        if (WIDTH < 2 || BITS_PER_CYCLE < 1 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_params
            $error("serial_subtractor: BITS_PER_CYCLE must divide WIDTH and WIDTH must be >= 2");
        end
    endgenerate

    typedef enum logic {IDLE, RUN} state_t;

    state_t                    state_q, state_d;
    logic [WIDTH-1:0]          a_sh, b_sh, res_sh, res_next;
    logic                      brw_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [WIDTH-1:0]          diff_q;
    logic                      bo_q, zero_q, done_q;
    logic [BITS_PER_CYCLE:0]   chunk;
    logic [BITS_PER_CYCLE-1:0] chunk_d;
    logic                      chunk_bo;
    logic                      accept, last;

    // Ripple of full-subtractor cells; returns {final borrow, difference bits}.
    function automatic logic [BITS_PER_CYCLE:0] sub_chunk(
        input logic [BITS_PER_CYCLE-1:0] x,
        input logic [BITS_PER_CYCLE-1:0] y,
        input logic                      bi
    );
        logic [BITS_PER_CYCLE-1:0] d;
        logic                      br;
        br = bi;
        d  = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            d[i] = x[i] ^ y[i] ^ br;
            br   = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & br);
        end
        return {br, d};
    endfunction

    assign chunk    = sub_chunk(a_sh[BITS_PER_CYCLE-1:0], b_sh[BITS_PER_CYCLE-1:0], brw_q);
    assign chunk_d  = chunk[BITS_PER_CYCLE-1:0];
    assign chunk_bo = chunk[BITS_PER_CYCLE];

    // New chunk enters the working result from the MSB side.
    generate
        if (BITS_PER_CYCLE == WIDTH) begin : g_full_chunk
            assign res_next = chunk_d;
        end else begin : g_part_chunk
            assign res_next = {chunk_d, res_sh[WIDTH-1:BITS_PER_CYCLE]};
        end
    endgenerate

    assign accept = (state_q == IDLE) && start;
    assign last   = (state_q == RUN) && (cnt_q == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (cnt_q == LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            brw_q  <= 1'b0;
            cnt_q  <= '0;
            diff_q <= '0;
            bo_q   <= 1'b0;
            zero_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                a_sh  <= a;
                b_sh  <= b;
                brw_q <= borrow_in;
                cnt_q <= '0;
            end else if (state_q == RUN) begin
                a_sh   <= a_sh >> BITS_PER_CYCLE;
                b_sh   <= b_sh >> BITS_PER_CYCLE;
                res_sh <= res_next;
                brw_q  <= chunk_bo;
                cnt_q  <= cnt_q + CNT_W'(1);
                // Visible outputs only move on the final chunk.
                if (last) begin
                    diff_q <= res_next;
                    bo_q   <= chunk_bo;
                    zero_q <= (res_next == '0);
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign busy       = (state_q == RUN);
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = bo_q;
    assign zero       = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed and random operations on an 8-bit/1-bpc and a
// 16-bit/4-bpc instance, compared against an arithmetic reference model.
`timescale 1ns/1ps
module tb_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst;
    logic        start8, bin8, busy8, done8, bo8, zero8;
    logic [7:0]  a8, b8, diff8;
    logic        start16, bin16, busy16, done16, bo16, zero16;
    logic [15:0] a16, b16, diff16;

    int total  = 0;
    int passed = 0;

    serial_subtractor #(.WIDTH(8), .BITS_PER_CYCLE(1)) u8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .borrow_in(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8), .zero(zero8)
    );

    serial_subtractor #(.WIDTH(16), .BITS_PER_CYCLE(4)) u16 (
        .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .borrow_in(bin16),
        .busy(busy16), .done(done16), .diff(diff16), .borrow_out(bo16), .zero(zero16)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish (checks %0d/%0d)", passed, total);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: {borrow, diff} from plain unsigned arithmetic one bit wider than the operands.
    function automatic logic [16:0] model(input bit w16, input logic [15:0] av,
                                          input logic [15:0] bv, input logic bi);
        logic [16:0] r;
        logic [8:0]  r8;
        if (w16) begin
            r = {1'b0, av} - {1'b0, bv} - 17'(bi);
            return r;
        end
        r8 = {1'b0, av[7:0]} - {1'b0, bv[7:0]} - 9'(bi);
        return {r8[8], 8'h00, r8[7:0]};
    endfunction

    // Called at a negedge; mode 0 = plain, 1 = extra start while busy, 2 = return in the done cycle.
    task automatic op(input bit w16, input logic [15:0] av, input logic [15:0] bv,
                      input logic bi, input int mode, input string tag);
        int          n;
        int          cyc;
        int          busy_cnt;
        logic [16:0] exp;
        logic [15:0] held;
        logic [15:0] od;
        n        = w16 ? 4 : 8;
        busy_cnt = 0;
        exp      = model(w16, av, bv, bi);
        held     = w16 ? diff16 : {8'h00, diff8};
        if (w16) begin start16 = 1'b1; a16 = av; b16 = bv; bin16 = bi; end
        else     begin start8 = 1'b1; a8 = av[7:0]; b8 = bv[7:0]; bin8 = bi; end
        @(posedge clk);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin start8 = 1'b0; start16 = 1'b0; end
            if (mode == 1 && cyc == 3) begin start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; bin8 = 1'b0; end
            if (mode == 1 && cyc == 4) start8 = 1'b0;
            if (w16 ? busy16 : busy8) busy_cnt++;
            if (cyc == 2) chk({tag, "_hold"}, 32'(w16 ? diff16 : {8'h00, diff8}), 32'(held));
        end while (!(w16 ? done16 : done8) && cyc < n + 4);
        od = w16 ? diff16 : {8'h00, diff8};
        chk({tag, "_latency"}, 32'(cyc - 1), 32'(n));
        chk({tag, "_busycyc"}, 32'(busy_cnt), 32'(n));
        chk({tag, "_busy_at_done"}, 32'(w16 ? busy16 : busy8), 32'(0));
        chk({tag, "_diff"}, 32'(od), 32'(exp[15:0]));
        chk({tag, "_borrow"}, 32'(w16 ? bo16 : bo8), 32'(exp[16]));
        chk({tag, "_zero"}, 32'(w16 ? zero16 : zero8), 32'(exp[15:0] == 16'h0000));
        if (mode != 2) begin
            @(negedge clk);
            chk({tag, "_done_width"}, 32'(w16 ? done16 : done8), 32'(0));
        end
    endtask

    initial begin
        int          dn;
        logic [31:0] r;
        rst = 1'b1;
        start8 = 0; a8 = 0; b8 = 0; bin8 = 0;
        start16 = 0; a16 = 0; b16 = 0; bin16 = 0;
        repeat (2) @(negedge clk);
        chk("reset8", 32'({busy8, done8, diff8, bo8, zero8}), 32'(0));
        chk("reset16", 32'({busy16, done16, diff16, bo16, zero16}), 32'(0));
        rst = 1'b0;
        @(negedge clk);

        op(0, 16'h05, 16'h03, 1'b0, 0, "s05_03");
        chk("s05_03_const", 32'({bo8, zero8, diff8}), 32'({1'b0, 1'b0, 8'h02}));
        op(0, 16'h03, 16'h05, 1'b0, 0, "s03_05");
        chk("s03_05_const", 32'({bo8, diff8}), 32'({1'b1, 8'hFE}));
        op(0, 16'h00, 16'h00, 1'b1, 0, "s00_00_b1");
        chk("s00_00_b1_const", 32'({bo8, diff8}), 32'({1'b1, 8'hFF}));
        op(0, 16'hFF, 16'hFF, 1'b0, 0, "sFF_FF");
        chk("sFF_FF_const", 32'({bo8, zero8, diff8}), 32'({1'b0, 1'b1, 8'h00}));

        for (int x = 0; x < 2; x++) begin
            for (int y = 0; y < 2; y++) begin
                op(0, 16'(x), 16'(y), 1'b0, 0, "half");
                chk("half_bit0", 32'(diff8[0]), 32'(x ^ y));
                chk("half_borrow", 32'(bo8), 32'((x == 0) && (y == 1)));
            end
        end

        op(0, 16'h10, 16'h01, 1'b0, 1, "busy_start");
        chk("busy_start_const", 32'(diff8), 32'(8'h0F));
        dn = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) dn++;
        end
        chk("busy_start_extra_done", 32'(dn), 32'(0));

        op(0, 16'h20, 16'h01, 1'b0, 2, "b2b_first");
        op(0, 16'h40, 16'h0F, 1'b1, 0, "b2b_second");
        op(0, 16'h05, 16'h03, 1'b0, 0, "pre_reset");

        start8 = 1'b1; a8 = 8'h77; b8 = 8'h11; bin8 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("midrun_reset", 32'({busy8, done8, diff8, bo8, zero8}), 32'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        dn = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8 || busy8) dn++;
        end
        chk("after_reset_quiet", 32'(dn), 32'(0));
        op(0, 16'hC4, 16'h3A, 1'b1, 0, "after_reset");

        op(1, 16'h1234, 16'h4321, 1'b0, 0, "w16_1234");
        chk("w16_1234_const", 32'({bo16, diff16}), 32'({1'b1, 16'hCF13}));
        op(1, 16'hFFFF, 16'hFFFF, 1'b0, 0, "w16_zero");

        for (int i = 0; i < 500; i++) begin
            r = $urandom;
            op(0, {8'h00, r[7:0]}, {8'h00, r[15:8]}, r[16], 0, "rand8");
        end
        for (int i = 0; i < 500; i++) begin
            r = $urandom;
            op(1, r[15:0], r[31:16], r[i % 16], 0, "rand16");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
